uart_tx_arb: RTL

Round-robin arbiter that shares one `uart_tx` transmitter between `NUM_REQ` byte sources. It sits directly upstream of `uart_tx`: it drives that block's `i_data`/`i_valid` and consumes its one-cycle `o_ready` accept pulse. It optionally holds the grant across multi-byte packets so that frames from different sources never interleave on the line.

---
 rtl/uart_arb_pkg.sv | 19 +
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_arb.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx round-robin arbiter.
package uart_arb_pkg;

   localparam int unsigned UART_ARB_MAX_REQ = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2
   } arb_state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first requester strictly after i_last_ptr,
// wrapping modulo NUM_REQ; returns one-hot grant and its index.
module uart_rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDXW    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDXW-1:0]    i_last_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDXW-1:0]    o_idx
);

   logic        found;
   int unsigned cand;

   // Rotating scan keeps the priority order relative to the last owner.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      found   = 1'b0;
      cand    = 0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = 32'(i_last_ptr) + off;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found && i_req[cand[IDXW-1:0]]) begin
            found                   = 1'b1;
            o_idx                   = cand[IDXW-1:0];
            o_grant                 = '0;
            o_grant[cand[IDXW-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte sources.
// Optional locked-grant timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arb
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned DATA_BIT = 8,
   parameter int unsigned LOCK_PKT = 1,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   input  logic [NUM_REQ*DATA_BIT-1:0]  i_req_data,
   input  logic [NUM_REQ-1:0]           i_req_last,
   output logic [NUM_REQ-1:0]           o_req_ready,
   output logic [NUM_REQ-1:0]           o_grant,
   output logic [DATA_BIT-1:0]          o_tx_data,
   output logic                         o_tx_valid,
   input  logic                         i_tx_ready,
   output logic                         o_busy
);

   localparam int unsigned IDXW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;

   arb_state_e            state_q, state_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [IDXW-1:0]       idx_q, idx_d;
   logic [IDXW-1:0]       ptr_q, ptr_d;
   logic                  last_q, last_d;
   logic [DATA_BIT-1:0]   data_q, data_d;
   logic [NUM_REQ-1:0]    pick_grant;
   logic [IDXW-1:0]       pick_idx;
   logic                  xfer;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned TW = clog2(TIMEOUT + 1);
   logic [TW-1:0]         tmo_q, tmo_d;
`endif

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDXW    (IDXW)
   ) u_pick (
      .i_req      (i_req_valid),
      .i_last_ptr (ptr_q),
      .o_grant    (pick_grant),
      .o_idx      (pick_idx)
   );

   assign xfer = (state_q == ST_LOAD) && |(i_req_valid & grant_q);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      last_d  = last_q;
      data_d  = data_q;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_d   = '0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (|i_req_valid) begin
               grant_d = pick_grant;
               idx_d   = pick_idx;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               data_d  = i_req_data[idx_q*DATA_BIT +: DATA_BIT];
               last_d  = i_req_last[idx_q];
               state_d = ST_SEND;
            end
`ifdef UART_ARB_TIMEOUT_EN
            // A stalled owner forfeits the line and is rotated to lowest priority.
            else if (tmo_q == TW'(TIMEOUT - 1)) begin
               ptr_d   = idx_q;
               grant_d = '0;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
`endif
         end
         ST_SEND: begin
            if (i_tx_ready) begin
               if ((LOCK_PKT != 0) && !last_q) begin
                  state_d = ST_LOAD;
               end else begin
                  ptr_d   = idx_q;
                  grant_d = '0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= IDXW'(NUM_REQ - 1);
         last_q  <= 1'b0;
         data_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         last_q  <= last_d;
         data_q  <= data_d;
`ifdef UART_ARB_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign o_req_ready = (state_q == ST_LOAD) ? grant_q : '0;
   assign o_grant     = grant_q;
   assign o_tx_data   = data_q;
   assign o_tx_valid  = (state_q == ST_SEND);
   assign o_busy      = (state_q != ST_IDLE);

endmodule
